// File: rtl/fetch_pkg.sv
// Constants and IF/ID bundle shared by the fetch, decode and execute stages.
package fetch_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_INC = 32'd4;
    localparam logic [WORD_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc_plus4;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register with hold and flush controls.
module ifid_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc_plus4,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4
);

    if_id_t r;

    // flush keeps pc_plus4 so the link value of the last real fetch survives
    always_ff @(posedge clk) begin
        if (reset) begin
            r.valid    <= 1'b0;
            r.instr    <= NOP_INSTR;
            r.pc_plus4 <= '0;
        end else if (flush) begin
            r.valid <= 1'b0;
            r.instr <= NOP_INSTR;
        end else if (!hold) begin
            r.valid    <= 1'b1;
            r.instr    <= load_instr;
            r.pc_plus4 <= load_pc_plus4;
        end
    end

    assign valid    = r.valid;
    assign instr    = r.instr;
    assign pc_plus4 = r.pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection, IF/ID register, counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        misalign_err,
    output logic [31:0] perf_fetch_count,
    output logic [31:0] perf_flush_count
);

    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_next;
    logic [WORD_W-1:0] pc_plus4;
    logic              fetch_en;

    assign pc_plus4  = pc + PC_INC;
    assign fetch_en  = !redirect && !stall;
    assign imem_addr = pc;

    always_comb begin
        pc_next = pc;
        priority case (1'b1)
            redirect: pc_next = {redirect_target[31:2], 2'b00};
            stall:    pc_next = pc;
            default:  pc_next = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc               <= {RESET_PC[31:2], 2'b00};
            misalign_err     <= 1'b0;
            perf_fetch_count <= '0;
            perf_flush_count <= '0;
        end else begin
            pc <= pc_next;
            if (redirect && (redirect_target[1:0] != 2'b00))
                misalign_err <= 1'b1;
            if (fetch_en)
                perf_fetch_count <= perf_fetch_count + 32'd1;
            if (redirect)
                perf_flush_count <= perf_flush_count + 32'd1;
        end
    end

    ifid_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_ifid (
        .clk          (clk),
        .reset        (reset),
        .hold         (stall),
        .flush        (redirect),
        .load_instr   (imem_data),
        .load_pc_plus4(pc_plus4),
        .valid        (ifid_valid),
        .instr        (ifid_instr),
        .pc_plus4     (ifid_pc_plus4)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        misalign_err;
    logic [31:0] perf_fetch_count;
    logic [31:0] perf_flush_count;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rd;
        logic [31:0] tgt;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ins;
        logic [31:0] pp4;
        logic        mis;
        logic [31:0] fc;
        logic [31:0] flc;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0:   mem = 32'h2008_0001;
            32'h4:   mem = 32'h2009_0002;
            32'h8:   mem = 32'h200A_0003;
            32'hC:   mem = 32'h200B_0004;
            default: mem = 32'h1300_0000 ^ a;
        endcase
    endfunction

    assign imem_data = mem(imem_addr);

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .ifid_valid      (ifid_valid),
        .ifid_instr      (ifid_instr),
        .ifid_pc_plus4   (ifid_pc_plus4),
        .misalign_err    (misalign_err),
        .perf_fetch_count(perf_fetch_count),
        .perf_flush_count(perf_flush_count)
    );

    task automatic add(input logic r, input logic s, input logic d,
                       input logic [31:0] t, input logic [31:0] a,
                       input logic v, input logic [31:0] i,
                       input logic [31:0] p, input logic m,
                       input logic [31:0] f, input logic [31:0] fl);
        vec_t x;
        x.rst = r; x.stl = s; x.rd = d; x.tgt = t;
        x.addr = a; x.vld = v; x.ins = i; x.pp4 = p;
        x.mis = m; x.fc = f; x.flc = fl;
        tbl.push_back(x);
    endtask

    task automatic apply(input vec_t x, input string name);
        reset = x.rst;
        stall = x.stl;
        redirect = x.rd;
        redirect_target = x.tgt;
        @(posedge clk);
        #1;
        n_vec++;
        if (imem_addr !== x.addr || ifid_valid !== x.vld ||
            ifid_instr !== x.ins || ifid_pc_plus4 !== x.pp4 ||
            misalign_err !== x.mis || perf_fetch_count !== x.fc ||
            perf_flush_count !== x.flc) begin
            n_bad++;
            $display("FAIL %s: got addr=%h v=%b ins=%h pp4=%h mis=%b fc=%0d flc=%0d want addr=%h v=%b ins=%h pp4=%h mis=%b fc=%0d flc=%0d",
                     name, imem_addr, ifid_valid, ifid_instr, ifid_pc_plus4,
                     misalign_err, perf_fetch_count, perf_flush_count,
                     x.addr, x.vld, x.ins, x.pp4, x.mis, x.fc, x.flc);
        end
    endtask

    initial begin
        vec_t h;
        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_target = '0;

        //   rst s  rd tgt           addr          v  instr         pp4           m  fc  flc
        add(1, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0, 0,  0); // 0 reset
        add(0, 0, 0, 32'h0,        32'h4,        1, 32'h20080001, 32'h4,        0, 1,  0); // 1
        add(0, 0, 0, 32'h0,        32'h8,        1, 32'h20090002, 32'h8,        0, 2,  0); // 2
        add(0, 1, 0, 32'h0,        32'h8,        1, 32'h20090002, 32'h8,        0, 2,  0); // 3 stall
        add(0, 1, 0, 32'h0,        32'h8,        1, 32'h20090002, 32'h8,        0, 2,  0); // 4
        add(0, 1, 0, 32'h0,        32'h8,        1, 32'h20090002, 32'h8,        0, 2,  0); // 5
        add(0, 0, 0, 32'h0,        32'hC,        1, 32'h200A0003, 32'hC,        0, 3,  0); // 6
        add(0, 0, 0, 32'h0,        32'h10,       1, 32'h200B0004, 32'h10,       0, 4,  0); // 7
        add(0, 1, 1, 32'h40,       32'h40,       0, 32'h0,        32'h10,       0, 4,  1); // 8 redir+stall
        add(0, 0, 0, 32'h0,        32'h44,       1, 32'h13000040, 32'h44,       0, 5,  1); // 9
        add(0, 0, 0, 32'h0,        32'h48,       1, 32'h13000044, 32'h48,       0, 6,  1); // 10
        add(0, 0, 1, 32'h42,       32'h40,       0, 32'h0,        32'h48,       1, 6,  2); // 11 misalign
        add(0, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 32'h0,        32'h68,       1, 16, 3); // 12
        add(0, 0, 0, 32'h0,        32'h0,        1, 32'hECFFFFFC, 32'h0,        1, 17, 3); // 13 wrap
        add(0, 0, 0, 32'h0,        32'h4,        1, 32'h20080001, 32'h4,        1, 18, 3); // 14
        add(0, 1, 1, 32'h20,       32'h20,       0, 32'h0,        32'h4,        1, 18, 4); // 15
        add(0, 1, 0, 32'h0,        32'h20,       0, 32'h0,        32'h4,        1, 18, 4); // 16
        add(1, 1, 1, 32'h80,       32'h0,        0, 32'h0,        32'h0,        0, 0,  0); // 17 reset
        add(0, 0, 0, 32'h0,        32'h4,        1, 32'h20080001, 32'h4,        0, 1,  0); // 18

        for (int i = 0; i <= 11; i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // sticky misalign flag across ten free-running cycles
        for (int i = 0; i < 10; i++) begin
            h.rst = 0; h.stl = 0; h.rd = 0; h.tgt = '0;
            h.addr = 32'h44 + 32'(4 * i);
            h.vld = 1;
            h.ins = 32'h1300_0000 ^ (32'h40 + 32'(4 * i));
            h.pp4 = h.addr;
            h.mis = 1;
            h.fc = 32'(7 + i);
            h.flc = 2;
            apply(h, $sformatf("sticky%0d", i));
        end

        for (int i = 12; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000: instruction word inserted into IF/ID on bubble or flush.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  from hazard unit; hold PC and IF/ID contents.
REQ-006 redirect  input  1  taken branch or jump resolved downstream.
REQ-007 redirect_target  input  32  new PC when redirect is high.
REQ-008 imem_addr  output  32  instruction memory byte address; equals PC combinationally.
REQ-009 imem_data  input  32  instruction word returned combinationally for imem_addr.
REQ-010 ifid_valid  output  1  IF/ID register holds a real instruction.
REQ-011 ifid_instr  output  32  registered instruction for decode.
REQ-012 ifid_pc_plus4  output  32  registered PC+4 of that instruction, for branch/jump/link.
REQ-013 misalign_err  output  1  sticky flag: a redirect target had nonzero bits [1:0].
REQ-014 perf_fetch_count  output  32  count of instructions accepted into IF/ID.
REQ-015 perf_flush_count  output  32  count of cycles with redirect high.

Function
REQ-016 Each cycle, priority: reset > redirect > stall > normal advance.
REQ-017 Normal advance: PC <= PC+4; ifid_instr <= imem_data; ifid_pc_plus4 <= PC+4; ifid_valid <= 1; perf_fetch_count increments.
REQ-018 Stall, no redirect: PC, ifid_instr, ifid_pc_plus4 and ifid_valid hold; no counter changes.
REQ-019 Redirect, with or without stall: PC <= {redirect_target[31:2],2'b00}; ifid_instr <= NOP_INSTR; ifid_valid <= 0; ifid_pc_plus4 holds; perf_flush_count increments.
REQ-020 Redirect with redirect_target[1:0] != 0 sets misalign_err, which stays 1 until reset.
REQ-021 PC arithmetic is modulo 2^32: PC 32'hFFFF_FFFC advances to 32'h0000_0000 with no error.
REQ-022 Both counters wrap from 32'hFFFF_FFFF to 0.
REQ-023 Latency: the instruction at address A appears on ifid_instr one rising edge after imem_addr==A with stall and redirect low.
REQ-024 Redirect takes effect on the next edge: the instruction at redirect_target appears in IF/ID two edges after redirect is sampled high.
REQ-025 imem_addr[1:0] is always 2'b00.

Reset
REQ-026 On a reset edge: PC=RESET_PC, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc_plus4=0, misalign_err=0, both counters 0.
REQ-027 Reset mid-stall or mid-redirect overrides both; the first fetch after reset deasserts is from RESET_PC.

Structure
REQ-028 Shared package holds WORD_W=32, PC_INC=4, NOP_INSTR default, and RESET_PC default; the decode and execute stages import the same constants.
REQ-029 One sub-module, ifid_reg, holds the IF/ID register with hold and flush controls; PC register, next-PC mux and counters live in fetch_stage.

Verification
REQ-030 Reset, then 4 cycles free run with memory words 0x20080001, 0x20090002, 0x200A0003, 0x200B0004 -> imem_addr 0,4,8,C; ifid_instr matches each word one edge later; ifid_pc_plus4 = 4,8,C,10; perf_fetch_count=4.
REQ-031 Stall high for 3 cycles at PC=8 -> imem_addr stays 8; ifid_instr stays the word at 4; counters unchanged; normal advance resumes on release.
REQ-032 Redirect to 0x40 with stall also high -> next edge PC=0x40, ifid_valid=0, ifid_instr=NOP; next edge ifid_instr=mem[0x40]; perf_flush_count=1.
REQ-033 Redirect to 0x42 -> PC=0x40, misalign_err=1, flag still 1 after 10 further cycles, cleared only by reset.
REQ-034 Redirect to 0xFFFFFFFC, then free run -> PC 0xFFFFFFFC then 0x00000000; ifid_pc_plus4=0x00000000.
REQ-035 Reset asserted for one cycle during a stall with PC=0x20 -> PC=RESET_PC, ifid_valid=0, all counters 0; run resumes from RESET_PC.
